// File: rtl/cpu_execute_dispatch_pkg.sv
// cpu_execute_dispatch_pkg
// Shared encodings for the execute-stage dispatch sequencer:
//   - TagSize      : default instruction tag width
//   - Unit*        : target execute unit encodings carried on i_unit / o_sel
//   - St*          : dispatch FSM state encodings
//   - unit_onehot  : unit code -> one-hot request vector (illegal -> none)
//   - unit_ready   : selects the ready pulse of the given unit
package cpu_execute_dispatch_pkg;

  localparam int unsigned TagSize = 4;

  localparam logic [1:0] UnitIb      = 2'd0;
  localparam logic [1:0] UnitCsr     = 2'd1;
  localparam logic [1:0] UnitMuldiv  = 2'd2;
  localparam logic [1:0] UnitIllegal = 2'd3;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  function automatic logic [2:0] unit_onehot(input logic [1:0] unit);
    logic [2:0] oh;
    oh = 3'b000;
    case (unit)
      UnitIb:     oh = 3'b001;
      UnitCsr:    oh = 3'b010;
      UnitMuldiv: oh = 3'b100;
      default:    oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Only the selected unit's ready counts; the illegal code never matches.
  function automatic logic unit_ready(input logic [2:0] ready, input logic [1:0] sel);
    logic r;
    r = 1'b0;
    case (sel)
      UnitIb:     r = ready[0];
      UnitCsr:    r = ready[1];
      UnitMuldiv: r = ready[2];
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_execute_dispatch.sv
// cpu_execute_dispatch
// Tag-driven execute-stage sequencer. A tag change from decode (while idle, not stalled and
// not flushed) issues a one-cycle request to one execute unit, then waits for that unit's
// ready pulse, retires the tag and holds the result-mux select. Flush discards the in-flight
// result (draining the unit first if it has not answered); a watchdog retires a stuck
// instruction after TIMEOUT cycles.
// Ports:
//   i_reset        sync active-high reset      i_clock   clock
//   i_stall        blocks new dispatch only    i_flush   discard in-flight result
//   i_tag          decode instruction tag      i_unit    target unit (3 = illegal)
//   i_unit_ready   one-hot ready [IB,CSR,MULDIV]
//   o_unit_request one-hot request pulse       o_sel     result mux select
//   o_tag          last retired tag            o_done    result valid pulse
//   o_illegal      illegal dispatch pulse      o_timeout watchdog pulse
//   o_busy         WAIT or DRAIN (combinational state decode)
module cpu_execute_dispatch
  import cpu_execute_dispatch_pkg::*;
#(
  // Must match TagSize used by the rest of the pipeline.
  parameter int unsigned TAG_WIDTH = TagSize,
  // Legal range 2..255.
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                 i_reset,
  input  logic                 i_clock,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic [TAG_WIDTH-1:0] i_tag,
  input  logic [1:0]           i_unit,
  input  logic [2:0]           i_unit_ready,
  output logic [2:0]           o_unit_request,
  output logic [1:0]           o_sel,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic                 o_done,
  output logic                 o_illegal,
  output logic                 o_timeout,
  output logic                 o_busy
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  logic [1:0]           state_q, state_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [TAG_WIDTH-1:0] pend_tag_q, pend_tag_d;
  logic [1:0]           sel_q, sel_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [2:0]           req_q, req_d;
  logic                 done_q, done_d;
  logic                 illegal_q, illegal_d;
  logic                 timeout_q, timeout_d;

  logic                 is_new;
  logic                 ready_sel;
  logic                 wd_fire;
  logic [7:0]           cnt_inc;

  assign is_new    = !i_stall && !i_flush && (i_tag != tag_q);
  assign ready_sel = unit_ready(i_unit_ready, sel_q);
  assign wd_fire   = (cnt_q == CntLast);
  assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    pend_tag_d = pend_tag_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    req_d      = 3'b000;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (is_new) begin
          if (i_unit == UnitIllegal) begin
            // Retire immediately so the same tag is not flagged again.
            tag_d     = i_tag;
            illegal_d = 1'b1;
          end else begin
            req_d      = unit_onehot(i_unit);
            pend_tag_d = i_tag;
            sel_d      = i_unit;
            cnt_d      = 8'd0;
            state_d    = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_inc;
        if (ready_sel) begin
          // Flush in the same cycle suppresses commit but still retires the tag.
          tag_d   = pend_tag_q;
          done_d  = !i_flush;
          state_d = StIdle;
        end else if (i_flush) begin
          state_d = StDrain;
        end else if (wd_fire) begin
          tag_d     = pend_tag_q;
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StDrain: begin
        // The unit still owes a ready pulse; absorb it before accepting new work.
        cnt_d = cnt_inc;
        if (ready_sel) begin
          tag_d   = pend_tag_q;
          state_d = StIdle;
        end else if (wd_fire) begin
          tag_d     = pend_tag_q;
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= StIdle;
      tag_q      <= '0;
      pend_tag_q <= '0;
      sel_q      <= UnitIb;
      cnt_q      <= 8'd0;
      req_q      <= 3'b000;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      pend_tag_q <= pend_tag_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_unit_request = req_q;
  assign o_sel          = sel_q;
  assign o_tag          = tag_q;
  assign o_done         = done_q;
  assign o_illegal      = illegal_q;
  assign o_timeout      = timeout_q;
  assign o_busy         = (state_q != StIdle);

endmodule

// File: tb/tb_cpu_execute_dispatch.sv
// Directed bench for cpu_execute_dispatch. A default instance (TIMEOUT = 64) covers dispatch,
// flush, stall, illegal and reset; a second instance with TIMEOUT = 8 shares the inputs and
// is checked only in the watchdog scenario.
module tb_cpu_execute_dispatch;

  logic       clk;
  logic       rst;
  logic       stall;
  logic       flush;
  logic [3:0] tag;
  logic [1:0] unit;
  logic [2:0] ready;

  logic [2:0] req,   req8;
  logic [1:0] sel,   sel8;
  logic [3:0] otag,  otag8;
  logic       done,  done8;
  logic       ill,   ill8;
  logic       to,    to8;
  logic       busy,  busy8;

  int n_cmp  = 0;
  int n_fail = 0;

  cpu_execute_dispatch #(.TAG_WIDTH(4), .TIMEOUT(64)) dut (
    .i_reset        (rst),
    .i_clock        (clk),
    .i_stall        (stall),
    .i_flush        (flush),
    .i_tag          (tag),
    .i_unit         (unit),
    .i_unit_ready   (ready),
    .o_unit_request (req),
    .o_sel          (sel),
    .o_tag          (otag),
    .o_done         (done),
    .o_illegal      (ill),
    .o_timeout      (to),
    .o_busy         (busy)
  );

  cpu_execute_dispatch #(.TAG_WIDTH(4), .TIMEOUT(8)) dut8 (
    .i_reset        (rst),
    .i_clock        (clk),
    .i_stall        (stall),
    .i_flush        (flush),
    .i_tag          (tag),
    .i_unit         (unit),
    .i_unit_ready   (ready),
    .o_unit_request (req8),
    .o_sel          (sel8),
    .o_tag          (otag8),
    .o_done         (done8),
    .o_illegal      (ill8),
    .o_timeout      (to8),
    .o_busy         (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tag = 4'd0; unit = 2'd0; ready = 3'b000; stall = 1'b0; flush = 1'b0;
    step();
    step();
    n_cmp++;
    if ({req, sel, otag, done, ill, to, busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b sel=%0d tag=%0d done=%b ill=%b to=%b busy=%b, want all 0",
               req, sel, otag, done, ill, to, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_ib();
    tag = 4'd1; unit = 2'd0;
    step();  // N+1: request cycle
    n_cmp++;
    if (req !== 3'b001) begin n_fail++; $display("FAIL ib_request: got %b want 001", req); end
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL ib_busy: got %b want 1", busy); end
    ready = 3'b001;
    step();  // N+2
    ready = 3'b000;
    n_cmp++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL ib_done: got %b want 1", done); end
    n_cmp++;
    if (otag !== 4'd1) begin n_fail++; $display("FAIL ib_tag: got %0d want 1", otag); end
    n_cmp++;
    if (sel !== 2'd0) begin n_fail++; $display("FAIL ib_sel: got %0d want 0", sel); end
    n_cmp++;
    if (req !== 3'b000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ib_idle: got req=%b busy=%b want 000/0", req, busy);
    end
    step();
    n_cmp++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL ib_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_muldiv();
    int busy_cnt = 0;
    int done_cnt = 0;
    tag = 4'd2; unit = 2'd2;
    step();
    n_cmp++;
    if (req !== 3'b100) begin n_fail++; $display("FAIL md_request: got %b want 100", req); end
    for (int k = 1; k <= 10; k++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (k == 3)  ready = 3'b010;  // stray CSR ready
      if (k == 10) ready = 3'b100;
      step();
      ready = 3'b000;
    end
    n_cmp++;
    if (busy_cnt != 10) begin n_fail++; $display("FAIL md_busy_cycles: got %0d want 10", busy_cnt); end
    n_cmp++;
    if (done_cnt != 0) begin n_fail++; $display("FAIL md_early_done: got %0d want 0", done_cnt); end
    n_cmp++;
    if (done !== 1'b1 || otag !== 4'd2 || sel !== 2'd2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL md_retire: got done=%b tag=%0d sel=%0d busy=%b want 1/2/2/0",
               done, otag, sel, busy);
    end
    step();
    n_cmp++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL md_done_once: got %b want 0", done); end
  endtask

  task automatic test_flush();
    int done_cnt = 0;
    int busy_cnt = 0;
    tag = 4'd3; unit = 2'd1;
    step();
    n_cmp++;
    if (req !== 3'b010) begin n_fail++; $display("FAIL fl_request: got %b want 010", req); end
    for (int k = 1; k <= 5; k++) begin
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cnt++;
      flush = (k == 2);
      if (k == 5) ready = 3'b010;
      step();
      flush = 1'b0;
      ready = 3'b000;
    end
    n_cmp++;
    if (busy_cnt != 5) begin n_fail++; $display("FAIL fl_drain_busy: got %0d want 5", busy_cnt); end
    n_cmp++;
    if (done !== 1'b0 || done_cnt != 0) begin
      n_fail++; $display("FAIL fl_no_done: got done=%b earlier=%0d want 0/0", done, done_cnt);
    end
    n_cmp++;
    if (otag !== 4'd3 || busy !== 1'b0) begin
      n_fail++; $display("FAIL fl_retire: got tag=%0d busy=%b want 3/0", otag, busy);
    end
    step();
    step();
    n_cmp++;
    if (req !== 3'b000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL fl_no_redispatch: got req=%b busy=%b want 000/0", req, busy);
    end
  endtask

  task automatic test_stall_illegal();
    int req_seen = 0;
    stall = 1'b1; tag = 4'd5; unit = 2'd0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (req !== 3'b000 || busy !== 1'b0) req_seen++;
    end
    n_cmp++;
    if (req_seen != 0) begin n_fail++; $display("FAIL st_blocked: got %0d dispatch cycles want 0", req_seen); end
    stall = 1'b0;
    step();
    n_cmp++;
    if (req !== 3'b001) begin n_fail++; $display("FAIL st_release: got %b want 001", req); end
    ready = 3'b001;
    step();
    ready = 3'b000;
    n_cmp++;
    if (done !== 1'b1 || otag !== 4'd5) begin
      n_fail++; $display("FAIL st_retire: got done=%b tag=%0d want 1/5", done, otag);
    end
    tag = 4'd6; unit = 2'd3;
    step();
    n_cmp++;
    if (ill !== 1'b1 || otag !== 4'd6 || req !== 3'b000 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL il_pulse: got ill=%b tag=%0d req=%b done=%b busy=%b want 1/6/000/0/0",
               ill, otag, req, done, busy);
    end
    step();
    n_cmp++;
    if (ill !== 1'b0) begin n_fail++; $display("FAIL il_once: got %b want 0", ill); end
  endtask

  task automatic test_reset_mid();
    tag = 4'd7; unit = 2'd2;
    step();
    n_cmp++;
    if (req !== 3'b100) begin n_fail++; $display("FAIL rm_request: got %b want 100", req); end
    step();
    rst = 1'b1; tag = 4'd0;
    step();
    rst = 1'b0;
    ready = 3'b100;  // late ready after reset
    step();
    ready = 3'b000;
    n_cmp++;
    if ({req, sel, otag, done, ill, to, busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL rm_outputs: got req=%b sel=%0d tag=%0d done=%b ill=%b to=%b busy=%b, want all 0",
               req, sel, otag, done, ill, to, busy);
    end
  endtask

  task automatic test_watchdog();
    int early_to = 0;
    rst = 1'b1; tag = 4'd0; unit = 2'd0; ready = 3'b000;
    step();
    rst = 1'b0;
    tag = 4'd4; unit = 2'd0;
    step();  // WAIT cycle 1
    for (int k = 1; k <= 8; k++) begin
      if (to8 === 1'b1) early_to++;
      step();
    end
    n_cmp++;
    if (early_to != 0) begin n_fail++; $display("FAIL wd_early: got %0d want 0", early_to); end
    n_cmp++;
    if (to8 !== 1'b1 || otag8 !== 4'd4 || done8 !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_fire: got to=%b tag=%0d done=%b busy=%b want 1/4/0/0",
               to8, otag8, done8, busy8);
    end
    tag = 4'd5;
    step();
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) ready = 3'b001;
      step();
      ready = 3'b000;
    end
    n_cmp++;
    if (done8 !== 1'b1 || to8 !== 1'b0 || otag8 !== 4'd5) begin
      n_fail++;
      $display("FAIL wd_ready_wins: got done=%b to=%b tag=%0d want 1/0/5", done8, to8, otag8);
    end
  endtask

  initial begin
    test_reset();
    test_basic_ib();
    test_muldiv();
    test_flush();
    test_stall_illegal();
    test_reset_mid();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
